demux_1xn_rr: RTL and testbench

Parametrised 1-to-N demultiplexer with registered outputs and per-channel valid/ready flow control; the successor of the fixed 1x2 delayed demux. One input word stream is steered either round-robin across all channels or by an explicit select, with one cycle of latency. It sits between a single producer and NUM_CH independent consumers, and backpressures the producer when the targeted channel is occupied.

---
 rtl/demux_pkg.sv | 23 ++
 rtl/demux_out_reg.sv | 45 ++++
 rtl/demux_1xn_rr.sv | 117 +++++++++++
 tb/tb_demux_1xn_rr.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-N round-robin demultiplexer.
// Optional feature macro: DEMUX_DROP_CNT_EN (enables the dropped-word counter).
package demux_pkg;

   // Steering modes sampled directly from the mode input every cycle.
   localparam logic MODE_RR  = 1'b0;
   localparam logic MODE_SEL = 1'b1;

   // Saturating dropped-word counter.
   localparam int unsigned           DROP_CNT_W   = 8;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

   // Select width for a given channel count; never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned num_ch);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < num_ch) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One output channel register: loads a word, drains on consumer ready.
// A load in the same cycle as a drain wins, so the channel stays valid.
module demux_out_reg
#(
   parameter int unsigned DATA_W = 4
)(
   input  logic              clk,
   input  logic              reset_L,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   input  logic              ready_in,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;

   // Next-state: load has priority over drain; data holds after a drain.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = data_in;
      end else if (valid_q && ready_in) begin
         valid_d = 1'b0;
      end
   end

   // Channel state register.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_out = valid_q;
   assign data_out  = data_q;

endmodule

// File: rtl/demux_1xn_rr.sv
// 1-to-N demultiplexer, round-robin or explicit-select steering, one cycle
// latency, per-channel valid/ready. Words aimed at a nonexistent channel are
// consumed and discarded.
// Optional feature macro: DEMUX_DROP_CNT_EN (saturating count of discarded
// words on drop_cnt; otherwise drop_cnt is tied to zero).
module demux_1xn_rr
   import demux_pkg::*;
#(
   parameter  int unsigned DATA_W = 4,
   parameter  int unsigned NUM_CH = 4,
   localparam int unsigned SEL_W  = sel_width(NUM_CH)
)(
   input  logic                       clk,
   input  logic                       reset_L,
   input  logic                       mode,
   input  logic                       valid_in,
   input  logic [DATA_W-1:0]          data_in,
   input  logic [SEL_W-1:0]           sel_in,
   output logic                       ready_out,
   input  logic [NUM_CH-1:0]          ready_in,
   output logic [NUM_CH-1:0]          valid_out,
   output logic [NUM_CH*DATA_W-1:0]   data_out,
   output logic [DROP_CNT_W-1:0]      drop_cnt
);

   logic [SEL_W-1:0]  rr_q, rr_d;
   logic [SEL_W-1:0]  tgt_c;
   logic              invalid_c;
   logic              xfer_c;
   logic              load_en_c;
   logic [NUM_CH-1:0] tgt_oh_c;
   logic [NUM_CH-1:0] load_c;

   // Target decode, upstream ready and per-channel load strobes.
   always_comb begin
      tgt_c     = rr_q;
      invalid_c = 1'b0;
      tgt_oh_c  = '0;
      load_c    = '0;
      if (mode == MODE_SEL) begin
         tgt_c     = sel_in;
         invalid_c = (32'(sel_in) >= NUM_CH);
      end
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         tgt_oh_c[k] = (32'(tgt_c) == k);
      end
      // An invalid target never blocks; otherwise only a full, stalled target does.
      ready_out = invalid_c || !(|(tgt_oh_c & valid_out & ~ready_in));
      xfer_c    = valid_in && ready_out;
      load_en_c = xfer_c && !invalid_c;
      if (load_en_c) begin
         load_c = tgt_oh_c;
      end
   end

   // Round-robin pointer advances only on a delivered round-robin word.
   always_comb begin
      rr_d = rr_q;
      if (load_en_c && (mode == MODE_RR)) begin
         if (32'(rr_q) == NUM_CH - 1) begin
            rr_d = '0;
         end else begin
            rr_d = rr_q + SEL_W'(1);
         end
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   // One output register per channel.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      demux_out_reg #(
         .DATA_W    (DATA_W)
      ) u_out_reg (
         .clk       (clk),
         .reset_L   (reset_L),
         .load      (load_c[k]),
         .data_in   (data_in),
         .ready_in  (ready_in[k]),
         .valid_out (valid_out[k]),
         .data_out  (data_out[k*DATA_W +: DATA_W])
      );
   end

`ifdef DEMUX_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_q, drop_d;

   // Count discarded words, holding at the maximum.
   always_comb begin
      drop_d = drop_q;
      if (xfer_c && invalid_c && (drop_q != DROP_CNT_MAX)) begin
         drop_d = drop_q + DROP_CNT_W'(1);
      end
   end

   // Drop counter register; cleared only by reset.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_1xn_rr.sv
// Self-checking bench for demux_1xn_rr: a 4-channel instance checked against
// a channel-occupancy model, plus a 3-channel instance for discarded selects.
module tb_demux_1xn_rr;

   localparam int DW = 4;
   localparam int N4 = 4;
   localparam int N3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_L;

   // 4-channel instance
   logic            mode, valid_in, ready_out;
   logic [DW-1:0]   data_in;
   logic [1:0]      sel_in;
   logic [N4-1:0]   ready_in, valid_out;
   logic [N4*DW-1:0] data_out;
   logic [7:0]      drop_cnt;

   // 3-channel instance
   logic            mode3, valid3, ready_out3;
   logic [DW-1:0]   data3;
   logic [1:0]      sel3;
   logic [N3-1:0]   ready3, valid_out3;
   logic [N3*DW-1:0] data_out3;
   logic [7:0]      drop3;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: what each channel holds and where round-robin points.
   bit            m_v[N4];
   logic [DW-1:0] m_d[N4];
   int            m_rr;

   demux_1xn_rr #(.DATA_W(DW), .NUM_CH(N4)) dut4 (
      .clk(clk), .reset_L(reset_L), .mode(mode), .valid_in(valid_in),
      .data_in(data_in), .sel_in(sel_in), .ready_out(ready_out),
      .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
      .drop_cnt(drop_cnt)
   );

   demux_1xn_rr #(.DATA_W(DW), .NUM_CH(N3)) dut3 (
      .clk(clk), .reset_L(reset_L), .mode(mode3), .valid_in(valid3),
      .data_in(data3), .sel_in(sel3), .ready_out(ready_out3),
      .ready_in(ready3), .valid_out(valid_out3), .data_out(data_out3),
      .drop_cnt(drop3)
   );

   function automatic void model_clear();
      for (int k = 0; k < N4; k++) begin
         m_v[k] = 1'b0;
         m_d[k] = '0;
      end
      m_rr = 0;
   endfunction

   function automatic int model_tgt();
      return (mode == 1'b1) ? int'(sel_in) : m_rr;
   endfunction

   function automatic bit model_ready();
      int t;
      t = model_tgt();
      return !m_v[t] || ready_in[t];
   endfunction

   function automatic logic [N4-1:0] model_vo();
      logic [N4-1:0] v;
      for (int k = 0; k < N4; k++) v[k] = m_v[k];
      return v;
   endfunction

   function automatic logic [N4*DW-1:0] model_do();
      logic [N4*DW-1:0] d;
      for (int k = 0; k < N4; k++) d[k*DW +: DW] = m_d[k];
      return d;
   endfunction

   // Apply 4-channel inputs just after a falling edge.
   task automatic drive(input logic md, input logic v, input logic [DW-1:0] d,
                        input logic [1:0] s, input logic [N4-1:0] r);
      @(negedge clk);
      mode = md; valid_in = v; data_in = d; sel_in = s; ready_in = r;
      #1;
   endtask

   // Advance through a rising edge, updating the model from the applied inputs.
   task automatic tick();
      bit rdy;
      int t;
      rdy = model_ready();
      t   = model_tgt();
      @(posedge clk);
      if (reset_L) begin
         for (int k = 0; k < N4; k++) if (m_v[k] && ready_in[k]) m_v[k] = 1'b0;
         if (valid_in && rdy) begin
            m_v[t] = 1'b1;
            m_d[t] = data_in;
            if (mode == 1'b0) m_rr = (m_rr + 1) % N4;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      valid_in = 1'b0; valid3 = 1'b0;
      reset_L = 1'b0;
      model_clear();
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      valid_in = 1'b0; valid3 = 1'b0;
      reset_L = 1'b0;
      model_clear();
      #1;
      n_checks++;
      if (valid_out !== '0 || data_out !== '0) begin
         n_fail++; $display("FAIL reset_outputs: valid_out=%b data_out=%h, want 0", valid_out, data_out);
      end
      n_checks++;
      if (ready_out !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: ready_out=%b, want 1", ready_out);
      end
      n_checks++;
      if (drop_cnt !== 8'd0 || drop3 !== 8'd0 || valid_out3 !== '0) begin
         n_fail++; $display("FAIL reset_drop: drop_cnt=%0d drop3=%0d v3=%b, want 0", drop_cnt, drop3, valid_out3);
      end
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < 8; i++) begin
         logic [N4-1:0] want_v;
         drive(1'b0, 1'b1, DW'(i + 1), 2'd0, '1);
         n_checks++;
         if (ready_out !== model_ready()) begin
            n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i, ready_out, model_ready());
         end
         tick();
         want_v = '0;
         want_v[i % N4] = 1'b1;
         n_checks++;
         if (valid_out !== want_v || data_out[(i % N4)*DW +: DW] !== DW'(i + 1)) begin
            n_fail++; $display("FAIL rr_word[%0d]: valid_out=%b data=%h want %b/%h",
                               i, valid_out, data_out[(i % N4)*DW +: DW], want_v, DW'(i + 1));
         end
         n_checks++;
         if (valid_out !== model_vo() || data_out !== model_do()) begin
            n_fail++; $display("FAIL rr_model[%0d]: %b/%h want %b/%h", i, valid_out, data_out, model_vo(), model_do());
         end
      end
      drive(1'b0, 1'b0, '0, 2'd0, '1);
      tick();
      n_checks++;
      if (valid_out !== '0) begin
         n_fail++; $display("FAIL rr_drain: valid_out=%b want 0000", valid_out);
      end
   endtask

   task automatic test_explicit();
      int rr_before;
      rr_before = m_rr;
      drive(1'b1, 1'b1, 4'hA, 2'd2, '1);
      tick();
      n_checks++;
      if (valid_out !== 4'b0100 || data_out[2*DW +: DW] !== 4'hA) begin
         n_fail++; $display("FAIL explicit_sel2: valid_out=%b data2=%h want 0100/a", valid_out, data_out[2*DW +: DW]);
      end
      drive(1'b0, 1'b1, 4'h3, 2'd0, '1);
      tick();
      n_checks++;
      if (valid_out[rr_before] !== 1'b1 || data_out[rr_before*DW +: DW] !== 4'h3) begin
         n_fail++; $display("FAIL explicit_rr_kept: valid_out=%b want ch%0d loaded", valid_out, rr_before);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      drive(1'b0, 1'b1, 4'h4, 2'd0, '1);      // ch0, pointer now 1
      tick();
      drive(1'b1, 1'b1, 4'h5, 2'd1, 4'b1101); // park 0x5 in ch1
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 4'h6, 2'd0, 4'b1101);
         n_checks++;
         if (ready_out !== 1'b0) begin
            n_fail++; $display("FAIL bp_stall[%0d]: ready_out=%b want 0", i, ready_out);
         end
         tick();
         n_checks++;
         if (valid_out[1] !== 1'b1 || data_out[1*DW +: DW] !== 4'h5) begin
            n_fail++; $display("FAIL bp_hold[%0d]: v1=%b d1=%h want 1/5", i, valid_out[1], data_out[1*DW +: DW]);
         end
      end
      drive(1'b0, 1'b1, 4'h6, 2'd0, 4'b1111);
      n_checks++;
      if (ready_out !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: ready_out=%b want 1", ready_out);
      end
      tick();
      n_checks++;
      if (valid_out[1] !== 1'b1 || data_out[1*DW +: DW] !== 4'h6) begin
         n_fail++; $display("FAIL bp_reload: v1=%b d1=%h want 1/6", valid_out[1], data_out[1*DW +: DW]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom), 1'($urandom_range(0, 3) != 0), DW'($urandom),
               2'($urandom), N4'($urandom));
         n_checks++;
         if (ready_out !== model_ready()) begin
            n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, ready_out, model_ready());
         end
         tick();
         n_checks++;
         if (valid_out !== model_vo() || data_out !== model_do()) begin
            n_fail++; $display("FAIL rand_out[%0d]: %b/%h want %b/%h", i, valid_out, data_out, model_vo(), model_do());
         end
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int i = 0; i < N4; i++) begin
         drive(1'b0, 1'b1, DW'(i + 9), 2'd0, '0);
         tick();
      end
      valid_in = 1'b0;
      #2;
      reset_L = 1'b0;
      model_clear();
      #1;
      n_checks++;
      if (valid_out !== '0 || data_out !== '0) begin
         n_fail++; $display("FAIL midreset_async: valid_out=%b data_out=%h want 0", valid_out, data_out);
      end
      @(negedge clk);
      reset_L = 1'b1;
      drive(1'b0, 1'b1, 4'hE, 2'd3, '1);
      tick();
      n_checks++;
      if (valid_out !== 4'b0001 || data_out[DW-1:0] !== 4'hE) begin
         n_fail++; $display("FAIL midreset_first: valid_out=%b d0=%h want 0001/e", valid_out, data_out[DW-1:0]);
      end
   endtask

   task automatic test_mode_switch();
      do_reset();
      drive(1'b0, 1'b1, 4'hB, 2'd0, '1); tick();
      drive(1'b0, 1'b1, 4'hC, 2'd0, '1); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, DW'(i), 2'($urandom), '1);
         tick();
      end
      drive(1'b0, 1'b1, 4'hD, 2'd0, '1);
      tick();
      n_checks++;
      if (valid_out !== 4'b0100 || data_out[2*DW +: DW] !== 4'hD) begin
         n_fail++; $display("FAIL mode_switch: valid_out=%b d2=%h want 0100/d", valid_out, data_out[2*DW +: DW]);
      end
   endtask

   task automatic test_invalid_select();
      int want_drop;
      do_reset();
      @(negedge clk);
      mode3 = 1'b1; valid3 = 1'b1; data3 = 4'h7; sel3 = 2'd2; ready3 = '0;
      #1;
      n_checks++;
      if (ready_out3 !== 1'b1) begin
         n_fail++; $display("FAIL inv_preload_ready: ready_out3=%b want 1", ready_out3);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         sel3 = 2'd3; data3 = DW'($urandom);
         #1;
         n_checks++;
         if (ready_out3 !== 1'b1) begin
            n_fail++; $display("FAIL inv_ready[%0d]: ready_out3=%b want 1", i, ready_out3);
         end
         @(posedge clk); #1;
`ifdef DEMUX_DROP_CNT_EN
         want_drop = (i + 1 > 255) ? 255 : i + 1;
`else
         want_drop = 0;
`endif
         n_checks++;
         if (valid_out3 !== 3'b100 || data_out3 !== 12'h700) begin
            n_fail++; $display("FAIL inv_nochange[%0d]: v3=%b d3=%h want 100/700", i, valid_out3, data_out3);
         end
         n_checks++;
         if (drop3 !== 8'(want_drop)) begin
            n_fail++; $display("FAIL inv_drop[%0d]: drop_cnt=%0d want %0d", i, drop3, want_drop);
         end
      end
      valid3 = 1'b0;
   endtask

   initial begin
      reset_L = 1'b0;
      mode = 1'b0; valid_in = 1'b0; data_in = '0; sel_in = '0; ready_in = '1;
      mode3 = 1'b0; valid3 = 1'b0; data3 = '0; sel3 = '0; ready3 = '1;
      model_clear();
      test_reset();
      test_round_robin();
      test_explicit();
      test_backpressure();
      test_random();
      test_reset_midstream();
      test_mode_switch();
      test_invalid_select();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
